// File: rtl/arith_issue.sv
`default_nettype none
// ============================================================================
// Module   : arith_issue
// Purpose  : Issue/capture stage around a combinational arithmetic unit.
//            Accepts one operation from decode (valid/ready), registers the
//            operands onto the unit's inputs, waits an opcode-dependent
//            settle time (multicycle path for mul/div), captures the unit
//            result and offers it with its destination address to writeback
//            (valid/ready).
// Ports    : clk, rst_n (async, active-low)
//            in_valid/in_ready, in_opcode, in_op1, in_op2, in_rd  <- decode
//            arith_opcode, arith_op1, arith_op2 -> unit; arith_out <- unit
//            out_valid/out_ready, out_result, out_rd, out_illegal -> writeback
//            busy (EXEC or DONE)
// Options  : ARITH_DIVZ_TRAP_EN adds out_divz and forces a divide with a zero
//            operand to return 16'hFFFF.
// Revision : 1.0 - initial release
// ============================================================================
module arith_issue #(
  parameter int MD_CYCLES = 3,  // settle cycles for mul/div, 1..15
  parameter int RD_W      = 3
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      in_opcode,
  input  logic [15:0]     in_op1,
  input  logic [15:0]     in_op2,
  input  logic [RD_W-1:0] in_rd,
  output logic [3:0]      arith_opcode,
  output logic [15:0]     arith_op1,
  output logic [15:0]     arith_op2,
  input  logic [15:0]     arith_out,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [15:0]     out_result,
  output logic [RD_W-1:0] out_rd,
  output logic            out_illegal,
  output logic            busy
`ifdef ARITH_DIVZ_TRAP_EN
  ,
  output logic            out_divz
`endif
);

  localparam logic [3:0] C_OP_MUL = 4'b0001;
  localparam logic [3:0] C_OP_DIV = 4'b0011;
  localparam logic [3:0] C_MD_M1  = 4'(MD_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t     r_state;
  state_t     w_next_state;
  logic [3:0] r_cnt;
  logic [3:0] w_cnt_load;
  logic       w_accept;
  logic       w_capture;
  logic       w_retire;

  // Counter preload is L-1 so that the capture edge lands exactly L edges
  // after the accept edge.
  assign w_cnt_load = ((in_opcode == C_OP_MUL) || (in_opcode == C_OP_DIV)) ? C_MD_M1 : 4'd0;

  assign w_accept  = (r_state == S_IDLE) && in_valid;
  assign w_capture = (r_state == S_EXEC) && (r_cnt == 4'd0);
  assign w_retire  = (r_state == S_DONE) && out_ready;

  // --------------------------------------------------------------------------
  // FSM state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // --------------------------------------------------------------------------
  // FSM next state and handshake outputs
  // --------------------------------------------------------------------------
  always_comb begin
    w_next_state = r_state;
    in_ready     = 1'b0;
    out_valid    = 1'b0;
    busy         = 1'b0;
    case (r_state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (w_accept) w_next_state = S_EXEC;
      end
      S_EXEC: begin
        busy = 1'b1;
        if (w_capture) w_next_state = S_DONE;
      end
      S_DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (w_retire) w_next_state = S_IDLE;
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Operand registers, settle counter and result capture
  // --------------------------------------------------------------------------
`ifdef ARITH_DIVZ_TRAP_EN
  logic w_divz;
  assign w_divz = (arith_opcode == C_OP_DIV) &&
                  ((arith_op1 == 16'd0) || (arith_op2 == 16'd0));
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt        <= 4'd0;
      arith_opcode <= 4'd0;
      arith_op1    <= 16'd0;
      arith_op2    <= 16'd0;
      out_rd       <= '0;
      out_result   <= 16'd0;
      out_illegal  <= 1'b0;
`ifdef ARITH_DIVZ_TRAP_EN
      out_divz     <= 1'b0;
`endif
    end else begin
      if (w_accept) begin
        arith_opcode <= in_opcode;
        arith_op1    <= in_op1;
        arith_op2    <= in_op2;
        out_rd       <= in_rd;
        r_cnt        <= w_cnt_load;
      end else if (r_state == S_EXEC) begin
        if (w_capture) begin
          out_illegal <= (arith_opcode > C_OP_DIV);
`ifdef ARITH_DIVZ_TRAP_EN
          out_result  <= w_divz ? 16'hFFFF : arith_out;
          out_divz    <= w_divz;
`else
          out_result  <= arith_out;
`endif
        end else begin
          r_cnt <= r_cnt - 4'd1;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_arith_issue.sv
`default_nettype none
// ============================================================================
// Module   : tb_arith_issue
// Purpose  : Self-checking bench for arith_issue with a behavioural model of
//            the combinational arithmetic unit and an expected-result queue.
// Revision : 1.0 - initial release
// ============================================================================
module tb_arith_issue;

  localparam int MD   = 3;
  localparam int RD_W = 3;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [3:0]      in_opcode = 4'd0;
  logic [15:0]     in_op1 = 16'd0;
  logic [15:0]     in_op2 = 16'd0;
  logic [RD_W-1:0] in_rd = '0;
  logic [3:0]      arith_opcode;
  logic [15:0]     arith_op1;
  logic [15:0]     arith_op2;
  logic [15:0]     arith_out;
  logic            out_valid;
  logic            out_ready = 1'b0;
  logic [15:0]     out_result;
  logic [RD_W-1:0] out_rd;
  logic            out_illegal;
  logic            busy;
`ifdef ARITH_DIVZ_TRAP_EN
  logic            out_divz;
`endif

  arith_issue #(.MD_CYCLES(MD), .RD_W(RD_W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_opcode    (in_opcode),
    .in_op1       (in_op1),
    .in_op2       (in_op2),
    .in_rd        (in_rd),
    .arith_opcode (arith_opcode),
    .arith_op1    (arith_op1),
    .arith_op2    (arith_op2),
    .arith_out    (arith_out),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_result   (out_result),
    .out_rd       (out_rd),
    .out_illegal  (out_illegal),
    .busy         (busy)
`ifdef ARITH_DIVZ_TRAP_EN
    ,
    .out_divz     (out_divz)
`endif
  );

  always #5 clk = ~clk;

  // Behavioural arithmetic unit: add, truncated mul, abs-diff, larger/smaller.
  function automatic logic [15:0] unit_model(input logic [3:0] op,
                                             input logic [15:0] a,
                                             input logic [15:0] b);
    logic [31:0] prod;
    logic [15:0] hi, lo;
    unit_model = 16'd0;
    case (op)
      4'b0000: unit_model = a + b;
      4'b0001: begin prod = a * b; unit_model = prod[15:0]; end
      4'b0010: unit_model = (a > b) ? (a - b) : (b - a);
      4'b0011: begin
        hi = (a > b) ? a : b;
        lo = (a > b) ? b : a;
        unit_model = (lo == 16'd0) ? 16'd0 : (hi / lo);
      end
      default: unit_model = 16'd0;
    endcase
  endfunction

  assign arith_out = unit_model(arith_opcode, arith_op1, arith_op2);

  typedef struct {
    logic [15:0]     res;
    logic [RD_W-1:0] rd;
    logic            ill;
    logic            divz;
    int              lat;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drive one operation, push its expected retirement, check operand capture.
  task automatic issue(input logic [3:0] op, input logic [15:0] a,
                       input logic [15:0] b, input logic [RD_W-1:0] rd);
    exp_t e;
    int   n;
    n = 0;
    while (!in_ready && n < 50) begin step(); n++; end
    check("in_ready_before_accept", in_ready, 1);
    e.res  = unit_model(op, a, b);
    e.divz = 1'b0;
`ifdef ARITH_DIVZ_TRAP_EN
    if (op == 4'b0011 && (a == 16'd0 || b == 16'd0)) begin
      e.res  = 16'hFFFF;
      e.divz = 1'b1;
    end
`endif
    e.rd  = rd;
    e.ill = (op > 4'b0011);
    e.lat = (op == 4'b0001 || op == 4'b0011) ? MD : 1;
    sb.push_back(e);
    in_valid = 1'b1; in_opcode = op; in_op1 = a; in_op2 = b; in_rd = rd;
    step();
    in_valid = 1'b0;
    check("arith_opcode", arith_opcode, op);
    check("arith_op1", arith_op1, a);
    check("arith_op2", arith_op2, b);
    check("busy_exec", busy, 1);
    check("in_ready_exec", in_ready, 0);
  endtask

  // Count edges from the accept to out_valid and compare with expected L.
  task automatic wait_result();
    int n;
    n = 0;
    while (!out_valid && n < 40) begin step(); n++; end
    check("latency", n, sb[0].lat);
  endtask

  // Keep out_ready low for some cycles: result must stay stable.
  task automatic hold(input int cycles);
    out_ready = 1'b0;
    repeat (cycles) begin
      step();
      check("hold_valid", out_valid, 1);
      check("hold_result", out_result, sb[0].res);
      check("hold_in_ready", in_ready, 0);
    end
  endtask

  task automatic retire();
    exp_t e;
    e = sb[0];
    check("out_valid", out_valid, 1);
    check("out_result", out_result, e.res);
    check("out_rd", out_rd, e.rd);
    check("out_illegal", out_illegal, e.ill);
`ifdef ARITH_DIVZ_TRAP_EN
    check("out_divz", out_divz, e.divz);
`endif
    out_ready = 1'b1;
    step();
    void'(sb.pop_front());
    out_ready = 1'b0;
    check("valid_after_retire", out_valid, 0);
    check("in_ready_after_retire", in_ready, 1);
    check("busy_after_retire", busy, 0);
  endtask

  initial begin
    // Reset state
    #1;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_out_result", out_result, 0);
    check("rst_out_rd", out_rd, 0);
    check("rst_arith_op1", arith_op1, 0);
    step(); step();
    rst_n = 1'b1;
    step();
    check("post_rst_in_ready", in_ready, 1);

    // Add: single-cycle settle
    issue(4'b0000, 16'h1234, 16'h0101, 3'd2);
    wait_result();
    retire();

    // Mul: multicycle settle, truncation by the unit
    issue(4'b0001, 16'h0100, 16'h0100, 3'd5);
    wait_result();
    retire();
    issue(4'b0001, 16'h0003, 16'h0005, 3'd6);
    wait_result();
    retire();

    // Abs-diff under backpressure, with an ignored second request
    issue(4'b0010, 16'h0005, 16'h0009, 3'd1);
    wait_result();
    in_valid = 1'b1; in_opcode = 4'b0000; in_op1 = 16'hFFFF; in_op2 = 16'h0001; in_rd = 3'd7;
    hold(4);
    in_valid = 1'b0;
    check("ignored_op1", arith_op1, 16'h0005);
    check("ignored_rd", out_rd, 3'd1);
    retire();
    issue(4'b0000, 16'hFFFF, 16'h0001, 3'd7);
    wait_result();
    retire();

    // Illegal opcode
    issue(4'b0111, 16'h0001, 16'h0002, 3'd4);
    wait_result();
    retire();

    // Reset in the middle of a divide
    issue(4'b0011, 16'h0064, 16'h0005, 3'd3);
    #3 rst_n = 1'b0;
    #1;
    check("midrst_busy", busy, 0);
    check("midrst_out_valid", out_valid, 0);
    check("midrst_in_ready", in_ready, 1);
    check("midrst_arith_op1", arith_op1, 0);
    check("midrst_arith_opcode", arith_opcode, 0);
    void'(sb.pop_back());
    @(negedge clk) rst_n = 1'b1;
    repeat (6) begin
      step();
      check("midrst_no_valid", out_valid, 0);
    end
    issue(4'b0011, 16'h0064, 16'h0005, 3'd3);
    wait_result();
    retire();

`ifdef ARITH_DIVZ_TRAP_EN
    issue(4'b0011, 16'h0010, 16'h0000, 3'd2);
    wait_result();
    retire();
    issue(4'b0011, 16'h0010, 16'h0004, 3'd2);
    wait_result();
    retire();
`endif

    check("scoreboard_empty", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
